// File: rtl/cache_control_if.sv
// ============================================================================
//  Module      : cache_control_if
//  Description : Signal bundle between the two-way cache controller and its
//                CPU port, way/LRU arrays, datapath and physical memory.
//                master = controller side, slave = datapath / environment side.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface cache_control_if #(
    parameter int CNT_W = 16
);
    // CPU request / response
    logic             mem_read;
    logic             mem_write;
    logic             mem_resp;

    // Tag compare and line state for the current index
    logic             hit0;
    logic             hit1;
    logic             valid0;
    logic             valid1;
    logic             dirty0;
    logic             dirty1;
    logic             lru_way;

    // LRU update controls
    logic             set_one_hit;
    logic             set_two_hit;
    logic             load_lru;

    // Way array write enables
    logic             load_data0;
    logic             load_data1;
    logic             load_tag0;
    logic             load_tag1;
    logic             set_dirty0;
    logic             set_dirty1;
    logic             clear_dirty0;
    logic             clear_dirty1;

    // Datapath steering
    logic             data_sel;
    logic             way_sel;
    logic             pmem_addr_sel;

    // Physical memory handshake
    logic             pmem_read;
    logic             pmem_write;
    logic             pmem_resp;

    // Performance counters
    logic [CNT_W-1:0] miss_count;
    logic [CNT_W-1:0] wb_count;

    modport master (
        input  mem_read, mem_write, hit0, hit1, valid0, valid1, dirty0, dirty1,
               lru_way, pmem_resp,
        output mem_resp, set_one_hit, set_two_hit, load_lru,
               load_data0, load_data1, load_tag0, load_tag1,
               set_dirty0, set_dirty1, clear_dirty0, clear_dirty1,
               data_sel, way_sel, pmem_addr_sel, pmem_read, pmem_write,
               miss_count, wb_count
    );

    modport slave (
        output mem_read, mem_write, hit0, hit1, valid0, valid1, dirty0, dirty1,
               lru_way, pmem_resp,
        input  mem_resp, set_one_hit, set_two_hit, load_lru,
               load_data0, load_data1, load_tag0, load_tag1,
               set_dirty0, set_dirty1, clear_dirty0, clear_dirty1,
               data_sel, way_sel, pmem_addr_sel, pmem_read, pmem_write,
               miss_count, wb_count
    );
endinterface

`default_nettype wire

// File: rtl/cache_control.sv
// ============================================================================
//  Module      : cache_control
//  Description : Control FSM for a two-way set-associative write-back cache.
//                Hits complete in the request cycle; misses optionally write
//                back the dirty LRU victim, then fetch the line into that
//                victim way, after which the held request hits in IDLE.
//                Saturating miss / writeback counters are provided.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cache_control #(
    parameter int CNT_W = 16
) (
    input  wire logic     clk,
    input  wire logic     reset,
    cache_control_if.master bus
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WRITEBACK = 2'd1,
        ST_ALLOCATE  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           r_state;
    logic             r_victim;
    logic [CNT_W-1:0] r_miss_count;
    logic [CNT_W-1:0] r_wb_count;

    logic w_req;
    logic w_wr;
    logic w_hit;
    logic w_hit_way;
    logic w_lru_dirty;

    logic w_mem_resp;
    logic w_set_one_hit;
    logic w_set_two_hit;
    logic w_load_lru;
    logic w_load_data0;
    logic w_load_data1;
    logic w_load_tag0;
    logic w_load_tag1;
    logic w_set_dirty0;
    logic w_set_dirty1;
    logic w_clear_dirty0;
    logic w_clear_dirty1;
    logic w_data_sel;
    logic w_way_sel;
    logic w_pmem_addr_sel;
    logic w_pmem_read;
    logic w_pmem_write;

    // A simultaneous read+write is serviced as a write; a double hit is way0.
    assign w_req     = bus.mem_read | bus.mem_write;
    assign w_wr      = bus.mem_write;
    assign w_hit     = bus.hit0 | bus.hit1;
    assign w_hit_way = ~bus.hit0 & bus.hit1;

    // Writeback is only needed when the live LRU victim holds modified data.
    assign w_lru_dirty = bus.lru_way ? (bus.valid1 & bus.dirty1)
                                     : (bus.valid0 & bus.dirty0);

    // State, latched victim way and saturating performance counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_victim     <= 1'b0;
            r_miss_count <= '0;
            r_wb_count   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_req && !w_hit) begin
                        r_victim <= bus.lru_way;
                        if (r_miss_count != c_CNT_MAX) begin
                            r_miss_count <= r_miss_count + c_CNT_ONE;
                        end
                        r_state <= w_lru_dirty ? ST_WRITEBACK : ST_ALLOCATE;
                    end
                end
                ST_WRITEBACK: begin
                    if (bus.pmem_resp) begin
                        if (r_wb_count != c_CNT_MAX) begin
                            r_wb_count <= r_wb_count + c_CNT_ONE;
                        end
                        r_state <= ST_ALLOCATE;
                    end
                end
                ST_ALLOCATE: begin
                    if (bus.pmem_resp) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Control outputs decoded from state and live inputs; everything idles low.
    always_comb begin
        w_mem_resp      = 1'b0;
        w_set_one_hit   = 1'b0;
        w_set_two_hit   = 1'b0;
        w_load_lru      = 1'b0;
        w_load_data0    = 1'b0;
        w_load_data1    = 1'b0;
        w_load_tag0     = 1'b0;
        w_load_tag1     = 1'b0;
        w_set_dirty0    = 1'b0;
        w_set_dirty1    = 1'b0;
        w_clear_dirty0  = 1'b0;
        w_clear_dirty1  = 1'b0;
        w_data_sel      = 1'b0;
        w_way_sel       = 1'b0;
        w_pmem_addr_sel = 1'b0;
        w_pmem_read     = 1'b0;
        w_pmem_write    = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_req && w_hit) begin
                    w_mem_resp    = 1'b1;
                    w_load_lru    = 1'b1;
                    w_set_one_hit = ~w_hit_way;
                    w_set_two_hit = w_hit_way;
                    w_way_sel     = w_hit_way;
                    if (w_wr) begin
                        // CPU merge data goes into the hitting way.
                        w_data_sel   = 1'b0;
                        w_load_data0 = ~w_hit_way;
                        w_load_data1 = w_hit_way;
                        w_set_dirty0 = ~w_hit_way;
                        w_set_dirty1 = w_hit_way;
                    end
                end
            end
            ST_WRITEBACK: begin
                // Victim tag/index addresses memory, victim way supplies data.
                w_pmem_write    = 1'b1;
                w_pmem_addr_sel = 1'b1;
                w_way_sel       = r_victim;
            end
            ST_ALLOCATE: begin
                w_pmem_read     = 1'b1;
                w_pmem_addr_sel = 1'b0;
                if (bus.pmem_resp) begin
                    // Fill the latched victim way with the fetched line, clean.
                    w_data_sel     = 1'b1;
                    w_load_data0   = ~r_victim;
                    w_load_data1   = r_victim;
                    w_load_tag0    = ~r_victim;
                    w_load_tag1    = r_victim;
                    w_clear_dirty0 = ~r_victim;
                    w_clear_dirty1 = r_victim;
                end
            end
            default: begin
                w_mem_resp = 1'b0;
            end
        endcase
    end

    assign bus.mem_resp      = w_mem_resp;
    assign bus.set_one_hit   = w_set_one_hit;
    assign bus.set_two_hit   = w_set_two_hit;
    assign bus.load_lru      = w_load_lru;
    assign bus.load_data0    = w_load_data0;
    assign bus.load_data1    = w_load_data1;
    assign bus.load_tag0     = w_load_tag0;
    assign bus.load_tag1     = w_load_tag1;
    assign bus.set_dirty0    = w_set_dirty0;
    assign bus.set_dirty1    = w_set_dirty1;
    assign bus.clear_dirty0  = w_clear_dirty0;
    assign bus.clear_dirty1  = w_clear_dirty1;
    assign bus.data_sel      = w_data_sel;
    assign bus.way_sel       = w_way_sel;
    assign bus.pmem_addr_sel = w_pmem_addr_sel;
    assign bus.pmem_read     = w_pmem_read;
    assign bus.pmem_write    = w_pmem_write;
    assign bus.miss_count    = r_miss_count;
    assign bus.wb_count      = r_wb_count;

endmodule

`default_nettype wire

// File: tb/tb_cache_control.sv
// ============================================================================
//  Module      : tb_cache_control
//  Description : Scoreboard bench for cache_control. A wide-counter DUT and a
//                2-bit-counter DUT see identical stimulus; expected control
//                vectors and counter values are queued per cycle and checked
//                by an independent monitor on the falling edge.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cache_control;

    // Control vector bit positions
    localparam logic [16:0] C_RESP = 17'h10000;
    localparam logic [16:0] C_ONE  = 17'h08000;
    localparam logic [16:0] C_TWO  = 17'h04000;
    localparam logic [16:0] C_LRU  = 17'h02000;
    localparam logic [16:0] C_LD0  = 17'h01000;
    localparam logic [16:0] C_LD1  = 17'h00800;
    localparam logic [16:0] C_LT0  = 17'h00400;
    localparam logic [16:0] C_LT1  = 17'h00200;
    localparam logic [16:0] C_SD0  = 17'h00100;
    localparam logic [16:0] C_SD1  = 17'h00080;
    localparam logic [16:0] C_CD0  = 17'h00040;
    localparam logic [16:0] C_CD1  = 17'h00020;
    localparam logic [16:0] C_DSEL = 17'h00010;
    localparam logic [16:0] C_WAY  = 17'h00008;
    localparam logic [16:0] C_PSEL = 17'h00004;
    localparam logic [16:0] C_PRD  = 17'h00002;
    localparam logic [16:0] C_PWR  = 17'h00001;

    localparam logic [16:0] C_WB0  = C_PWR | C_PSEL;
    localparam logic [16:0] C_WB1  = C_PWR | C_PSEL | C_WAY;
    localparam logic [16:0] C_HIT0 = C_RESP | C_LRU | C_ONE;
    localparam logic [16:0] C_HIT1 = C_RESP | C_LRU | C_TWO | C_WAY;
    localparam logic [16:0] C_FIL0 = C_PRD | C_LD0 | C_LT0 | C_CD0 | C_DSEL;
    localparam logic [16:0] C_FIL1 = C_PRD | C_LD1 | C_LT1 | C_CD1 | C_DSEL;

    typedef struct {
        string       name;
        logic [16:0] ctl;
        int          miss;
        int          wb;
        int          smiss;
        int          swb;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    int total = 0;
    int bad   = 0;

    exp_t sb[$];

    cache_control_if #(.CNT_W(16)) bus ();
    cache_control_if #(.CNT_W(2))  sbus ();

    cache_control #(.CNT_W(16)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    cache_control #(.CNT_W(2)) u_dut_small (
        .clk   (clk),
        .reset (reset),
        .bus   (sbus.master)
    );

    assign sbus.mem_read  = bus.mem_read;
    assign sbus.mem_write = bus.mem_write;
    assign sbus.hit0      = bus.hit0;
    assign sbus.hit1      = bus.hit1;
    assign sbus.valid0    = bus.valid0;
    assign sbus.valid1    = bus.valid1;
    assign sbus.dirty0    = bus.dirty0;
    assign sbus.dirty1    = bus.dirty1;
    assign sbus.lru_way   = bus.lru_way;
    assign sbus.pmem_resp = bus.pmem_resp;

    always #5 clk = ~clk;

    function automatic logic [16:0] pack_ctl();
        return {bus.mem_resp, bus.set_one_hit, bus.set_two_hit, bus.load_lru,
                bus.load_data0, bus.load_data1, bus.load_tag0, bus.load_tag1,
                bus.set_dirty0, bus.set_dirty1, bus.clear_dirty0, bus.clear_dirty1,
                bus.data_sel, bus.way_sel, bus.pmem_addr_sel, bus.pmem_read,
                bus.pmem_write};
    endfunction

    task automatic check_int(input string nm, input string what, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s %s: got %0d expected %0d", nm, what, act, exp);
        end
    endtask

    // Monitor: compare DUT outputs against the oldest queued expectation.
    always @(negedge clk) begin
        if (sb.size() != 0) begin
            exp_t e;
            logic [16:0] got;
            e   = sb.pop_front();
            got = pack_ctl();
            total++;
            if (got !== e.ctl) begin
                bad++;
                $display("FAIL %s ctl: got %05h expected %05h", e.name, got, e.ctl);
            end
            check_int(e.name, "miss_count",       int'(bus.miss_count),  e.miss);
            check_int(e.name, "wb_count",         int'(bus.wb_count),    e.wb);
            check_int(e.name, "miss_count(W=2)",  int'(sbus.miss_count), e.smiss);
            check_int(e.name, "wb_count(W=2)",    int'(sbus.wb_count),   e.swb);
        end
    end

    task automatic step(input string nm, input logic [16:0] ctl,
                        input int m, input int w, input int sm, input int sw);
        exp_t e;
        e.name  = nm;
        e.ctl   = ctl;
        e.miss  = m;
        e.wb    = w;
        e.smiss = sm;
        e.swb   = sw;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
        bus.hit0      = 1'b0;
        bus.hit1      = 1'b0;
        bus.valid0    = 1'b0;
        bus.valid1    = 1'b0;
        bus.dirty0    = 1'b0;
        bus.dirty1    = 1'b0;
        bus.lru_way   = 1'b0;
        bus.pmem_resp = 1'b0;
    endtask

    initial begin
        clear_inputs();
        reset = 1'b1;
        @(posedge clk);
        #1;
        step("reset", 17'h0, 0, 0, 0, 0);
        reset = 1'b0;
        step("idle_noreq", 17'h0, 0, 0, 0, 0);

        // Hits
        bus.mem_read = 1'b1; bus.hit1 = 1'b1;
        step("read_hit1", C_HIT1, 0, 0, 0, 0);
        clear_inputs();
        bus.mem_write = 1'b1; bus.hit0 = 1'b1;
        step("write_hit0", C_HIT0 | C_LD0 | C_SD0, 0, 0, 0, 0);
        clear_inputs();
        bus.mem_read = 1'b1; bus.hit0 = 1'b1; bus.hit1 = 1'b1;
        step("double_hit", C_HIT0, 0, 0, 0, 0);
        clear_inputs();
        bus.mem_read = 1'b1; bus.mem_write = 1'b1; bus.hit1 = 1'b1;
        step("rw_hit1", C_HIT1 | C_LD1 | C_SD1, 0, 0, 0, 0);
        clear_inputs();
        step("idle_after_hits", 17'h0, 0, 0, 0, 0);

        // Dirty-victim read miss on way1; live lru_way flips mid-writeback
        bus.mem_read = 1'b1; bus.lru_way = 1'b1;
        bus.valid1 = 1'b1; bus.dirty1 = 1'b1; bus.valid0 = 1'b1;
        step("miss_dirty_idle", 17'h0, 0, 0, 0, 0);
        bus.lru_way = 1'b0;
        step("wb_1", C_WB1, 1, 0, 1, 0);
        step("wb_2", C_WB1, 1, 0, 1, 0);
        bus.pmem_resp = 1'b1;
        step("wb_3_resp", C_WB1, 1, 0, 1, 0);
        bus.pmem_resp = 1'b0;
        step("alloc_1", C_PRD, 1, 1, 1, 1);
        step("alloc_2", C_PRD, 1, 1, 1, 1);
        bus.pmem_resp = 1'b1;
        step("alloc_3_fill1", C_FIL1, 1, 1, 1, 1);
        bus.pmem_resp = 1'b0; bus.hit1 = 1'b1; bus.dirty1 = 1'b0;
        step("post_fill_hit1", C_HIT1, 1, 1, 1, 1);
        clear_inputs();

        // Clean-victim miss on way0; live lru_way flips during allocate
        bus.mem_read = 1'b1; bus.lru_way = 1'b0;
        bus.valid0 = 1'b1; bus.valid1 = 1'b1; bus.dirty1 = 1'b1;
        step("miss_clean_idle", 17'h0, 1, 1, 1, 1);
        bus.lru_way = 1'b1;
        step("alloc_c1", C_PRD, 2, 1, 2, 1);
        bus.pmem_resp = 1'b1;
        step("alloc_c2_fill0", C_FIL0, 2, 1, 2, 1);
        bus.pmem_resp = 1'b0; bus.hit0 = 1'b1;
        step("post_fill_hit0", C_HIT0, 2, 1, 2, 1);
        clear_inputs();

        // Dirty but invalid victim needs no writeback; write miss
        bus.mem_write = 1'b1; bus.lru_way = 1'b0;
        bus.valid0 = 1'b0; bus.dirty0 = 1'b1;
        step("miss_invalid_idle", 17'h0, 2, 1, 2, 1);
        bus.pmem_resp = 1'b1;
        step("alloc_i_fill0", C_FIL0, 3, 1, 3, 1);
        bus.pmem_resp = 1'b0; bus.hit0 = 1'b1;
        step("post_fill_whit0", C_HIT0 | C_LD0 | C_SD0, 3, 1, 3, 1);
        clear_inputs();

        // Reset during writeback (2-bit miss counter already saturated)
        bus.mem_read = 1'b1; bus.lru_way = 1'b0;
        bus.valid0 = 1'b1; bus.dirty0 = 1'b1;
        step("miss_wb0_idle", 17'h0, 3, 1, 3, 1);
        step("wb0_1", C_WB0, 4, 1, 3, 1);
        reset = 1'b1; bus.pmem_resp = 1'b1;
        step("wb0_reset", C_WB0, 4, 1, 3, 1);
        reset = 1'b0; bus.mem_read = 1'b0;
        step("after_reset", 17'h0, 0, 0, 0, 0);
        step("resp_ignored", 17'h0, 0, 0, 0, 0);
        clear_inputs();

        // Five clean misses: the 2-bit counter saturates at 3
        for (int i = 0; i < 5; i++) begin
            bus.mem_read = 1'b1; bus.lru_way = 1'b1;
            bus.valid1 = 1'b1; bus.dirty1 = 1'b0; bus.hit0 = 1'b0;
            step("sat_miss", 17'h0, i, 0, (i < 3) ? i : 3, 0);
            bus.pmem_resp = 1'b1;
            step("sat_fill1", C_FIL1, i + 1, 0, (i + 1 < 3) ? i + 1 : 3, 0);
            bus.pmem_resp = 1'b0; bus.hit1 = 1'b1;
            step("sat_hit1", C_HIT1, i + 1, 0, (i + 1 < 3) ? i + 1 : 3, 0);
            clear_inputs();
        end
        step("final_idle", 17'h0, 5, 0, 3, 0);

        @(negedge clk);
        #1;
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d entries left expected 0", sb.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire

// File: doc/cache_control.md
CACHE_CONTROL -- requirements
Module: cache_control

Interface
REQ-001 SHALL have parameter CNT_W, default 16, giving the width of the saturating miss and writeback counters.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have ports mem_read and mem_write, input, 1 bit each: CPU request strobes, held by the CPU until mem_resp.
REQ-005 SHALL have port mem_resp, output, 1 bit: request complete.
REQ-006 SHALL have ports hit0 and hit1, input, 1 bit each: way0/way1 tag match AND valid for the current index, from the datapath.
REQ-007 SHALL have ports valid0, valid1, dirty0 and dirty1, input, 1 bit each: line state of each way at the current index.
REQ-008 SHALL have port lru_way, input, 1 bit: victim way for the current index (0 = evict way0, 1 = evict way1), driven by the LRU array.
REQ-009 SHALL have ports set_one_hit, set_two_hit and load_lru, output, 1 bit each: the LRU update controls.
REQ-010 SHALL have ports load_data0, load_data1, load_tag0, load_tag1, set_dirty0, set_dirty1, clear_dirty0 and clear_dirty1, output, 1 bit each: way array write enables.
REQ-011 SHALL have port data_sel, output, 1 bit: array write data source (0 = CPU merge, 1 = pmem line).
REQ-012 SHALL have port way_sel, output, 1 bit: way driving read mux and writeback data.
REQ-013 SHALL have port pmem_addr_sel, output, 1 bit: pmem address source (0 = CPU tag/index, 1 = victim tag/index).
REQ-014 SHALL have ports pmem_read and pmem_write, output, 1 bit each; and port pmem_resp, input, 1 bit.
REQ-015 SHALL have ports miss_count and wb_count, output, CNT_W bits each: performance counters.

Function
REQ-016 SHALL implement FSM states IDLE, WRITEBACK and ALLOCATE; all control outputs are combinational from state and inputs, and default to 0.
REQ-017 In IDLE with (mem_read|mem_write) and (hit0|hit1), it SHALL assert mem_resp and load_lru in the same cycle, plus set_one_hit for hit0 or set_two_hit for hit1, and SHALL remain in IDLE.
REQ-018 If hit0 and hit1 are both asserted (illegal), it SHALL treat the access as a way0 hit.
REQ-019 On a write hit it SHALL assert load_data<w> and set_dirty<w> for hit way w with data_sel=0 and way_sel=w; on a read hit it SHALL set way_sel=w only.
REQ-020 If mem_read and mem_write are both asserted, it SHALL service the access as a write.
REQ-021 On an IDLE miss it SHALL latch victim=lru_way into a register, increment miss_count (saturating), and go to WRITEBACK if the victim is valid and dirty, else to ALLOCATE.
REQ-022 In WRITEBACK it SHALL assert pmem_write, pmem_addr_sel=1 and way_sel=victim.
REQ-023 In WRITEBACK, on pmem_resp, it SHALL increment wb_count (saturating) and go to ALLOCATE.
REQ-024 In ALLOCATE it SHALL assert pmem_read with pmem_addr_sel=0.
REQ-025 In ALLOCATE, on pmem_resp, it SHALL assert load_data<victim>, load_tag<victim> and clear_dirty<victim> with data_sel=1 for one cycle, then go to IDLE.
REQ-026 After ALLOCATE, the still-held request SHALL hit in IDLE on the next cycle; miss latency SHALL be pmem cycles + 1.
REQ-027 It SHALL NOT assert mem_resp or load_lru in WRITEBACK or ALLOCATE.
REQ-028 Victim selection SHALL use the latched register, not live lru_way, outside IDLE.
REQ-029 Counters SHALL hold at 2^CNT_W-1 and not wrap.

Reset
REQ-030 When reset=1 at a clock edge, the block SHALL enter IDLE, clear victim to 0, and clear miss_count and wb_count to 0, regardless of state.
REQ-031 Reset mid-WRITEBACK or mid-ALLOCATE SHALL deassert pmem_read and pmem_write from the next cycle, and pending pmem_resp SHALL be ignored.
REQ-032 All outputs SHALL be 0 while in IDLE with no request.

Verification
REQ-033 Read, hit1=1 -> same-cycle mem_resp=1, load_lru=1, set_two_hit=1, state stays IDLE, counters unchanged.
REQ-034 Write, hit0=1 -> mem_resp=1, load_data0=1, set_dirty0=1, data_sel=0, set_one_hit=1.
REQ-035 Read miss, lru_way=1, valid1=1, dirty1=1; pmem_resp after 3 cycles twice -> WRITEBACK (pmem_write, pmem_addr_sel=1, way_sel=1), then ALLOCATE (pmem_read), then load_data1/load_tag1/clear_dirty1 with data_sel=1, then hit with mem_resp; miss_count=1, wb_count=1.
REQ-036 Miss with clean victim, lru_way toggled during ALLOCATE -> direct ALLOCATE, fill uses latched way, wb_count=0.
REQ-037 reset=1 during WRITEBACK -> next cycle IDLE, pmem_write=0, miss_count=0.
REQ-038 CNT_W=2, 5 misses -> miss_count=3.
